// File: rtl/btn_cond_pkg.sv
// rtl/btn_cond_pkg.sv - shared constants, index type and popcount for btn_conditioner
//
// Purpose: default channel count and debounce length, the press-index width
// and type, and a popcount helper. The encoder and the lock-clear logic both
// use the popcount.
// Ports: none (package).
package btn_cond_pkg;

  localparam int N_BTN_DEF           = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  // Width of an encoded button index at the default channel count.
  localparam int BTN_IDX_W = $clog2(N_BTN_DEF);
  typedef logic [BTN_IDX_W-1:0] btn_idx_t;

  // The popcount takes a fixed 8-bit input, which covers the maximum channel
  // count. Callers zero-extend their vectors to this width.
  localparam int POP_IN_W  = 8;
  localparam int POP_OUT_W = 4;

  function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
    logic [POP_OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < POP_IN_W; i++) begin
      n = n + POP_OUT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one push-button channel: synchroniser, stability counter, level, rise
//
// Purpose: brings one raw button into the clk domain through two flops. The
// debounced level changes only after the synchronised input has differed from
// it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   raw   in  asynchronous raw button level (1 = pressed)
//   level out debounced level (registered)
//   rise  out high in the cycle before level goes 0->1, so a register fed
//             from it updates on the same edge as level
module btn_debounce
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      // Agreement with the accepted level ends any mismatch run.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  // Driven by flops only, so there is no combinational path from raw.
  assign rise  = level_d & ~level_q;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - four-channel push-button front end with press pulses and encoder
//
// Purpose: debounces N_BTN buttons. It registers a one-cycle press pulse per
// accepted 0->1 transition. It encodes whether exactly one button (and which
// one) or several buttons were pressed in a cycle.
// Optional feature macro: BTN_COND_LOCKOUT_EN. When defined, after the first
// press, further presses are suppressed until every button is released.
// Ports:
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   btn_raw     in  [N_BTN] raw button levels (1 = pressed)
//   btn_level   out [N_BTN] debounced levels
//   btn_press   out [N_BTN] one-cycle pulse per debounced press
//   press_valid out exactly one btn_press bit set
//   press_code  out index of that bit, 0 when press_valid is 0
//   press_multi out two or more btn_press bits set
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_level,
  output logic [N_BTN-1:0]         btn_press,
  output logic                     press_valid,
  output logic [$clog2(N_BTN)-1:0] press_code,
  output logic                     press_multi
);

  localparam int IDX_W = $clog2(N_BTN);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] press_q, press_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[g]),
      .level(level[g]),
      .rise (rise[g])
    );
  end

`ifdef BTN_COND_LOCKOUT_EN
  logic lock_q, lock_d;

  always_comb begin
    lock_d = lock_q;
    if (lock_q) begin
      if (popcount(POP_IN_W'(level)) == '0) begin
        lock_d = 1'b0;
      end
    end else if (|press_q) begin
      lock_d = 1'b1;
    end
    // Levels keep tracking while locked; only the pulses are withheld.
    press_d = rise & {N_BTN{~lock_q}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  always_comb begin
    press_d = rise;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      press_q <= '0;
    end else begin
      press_q <= press_d;
    end
  end

  logic [POP_OUT_W-1:0] press_cnt;
  logic [IDX_W-1:0]     low_idx;

  always_comb begin
    press_cnt = popcount(POP_IN_W'(press_q));
    // Scan downwards so that the lowest set index is the last one written.
    low_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press_q[i]) begin
        low_idx = IDX_W'(i);
      end
    end
    press_valid = (press_cnt == POP_OUT_W'(1));
    press_multi = (press_cnt >= POP_OUT_W'(2));
    press_code  = press_valid ? low_idx : '0;
  end

  assign btn_level = level;
  assign btn_press = press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - table-driven self-checking bench for btn_conditioner
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic       press_valid;
  logic [1:0] press_code;
  logic       press_multi;

`ifdef BTN_COND_LOCKOUT_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .press_valid(press_valid),
    .press_code (press_code),
    .press_multi(press_multi)
  );

  typedef struct {
    logic [3:0] raw;
    logic       rst;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic       v;
    logic [1:0] code;
    logic       m;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(input int n, input logic [3:0] raw, input logic r,
                              input logic [3:0] lvl, input logic [3:0] prs,
                              input logic v, input logic [1:0] c, input logic m);
    vec_t e;
    e.raw = raw; e.rst = r; e.lvl = lvl; e.prs = prs; e.v = v; e.code = c; e.m = m;
    for (int k = 0; k < n; k++) tbl.push_back(e);
  endfunction

  task automatic check_row(input int idx, input vec_t e);
    n_tests++;
    if (btn_level !== e.lvl || btn_press !== e.prs || press_valid !== e.v ||
        press_code !== e.code || press_multi !== e.m) begin
      n_fail++;
      $display("FAIL row[%0d]: got lvl=%b prs=%b v=%b code=%0d multi=%b, want lvl=%b prs=%b v=%b code=%0d multi=%b",
               idx, btn_level, btn_press, press_valid, press_code, press_multi,
               e.lvl, e.prs, e.v, e.code, e.m);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  initial begin
    int p0, p2, code_at, valid_at;

    rst     = 1'b1;
    btn_raw = 4'b0000;

    // Reset state
    add(2, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0);
    // Clean press on ch3: level and press appear after edge 5; release 5 edges later
    add(5,  4'b1000, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(1,  4'b1000, 0, 4'b1000, 4'b1000, 1, 3, 0);
    add(14, 4'b1000, 0, 4'b1000, 4'b0000, 0, 0, 0);
    add(5,  4'b0000, 0, 4'b1000, 4'b0000, 0, 0, 0);
    add(1,  4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(2,  4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // Bounce on ch1: 3 high, 1 low, 3 high, 3 low give nothing; 6 high give one pulse
    add(3,  4'b0010, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(1,  4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(3,  4'b0010, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(3,  4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(5,  4'b0010, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(1,  4'b0010, 0, 4'b0010, 4'b0010, 1, 1, 0);
    add(5,  4'b0000, 0, 4'b0010, 4'b0000, 0, 0, 0);
    add(1,  4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(2,  4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // Simultaneous ch0+ch2
    add(5,  4'b0101, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(1,  4'b0101, 0, 4'b0101, 4'b0101, 0, 0, 1);
    add(2,  4'b0101, 0, 4'b0101, 4'b0000, 0, 0, 0);
    add(5,  4'b0000, 0, 4'b0101, 4'b0000, 0, 0, 0);
    add(1,  4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(2,  4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // Reset mid-count at edge 3, then reset while ch0 is held high
    add(3,  4'b0001, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(1,  4'b0001, 1, 4'b0000, 4'b0000, 0, 0, 0);
    add(5,  4'b0001, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(1,  4'b0001, 0, 4'b0001, 4'b0001, 1, 0, 0);
    add(2,  4'b0001, 0, 4'b0001, 4'b0000, 0, 0, 0);
    add(1,  4'b0001, 1, 4'b0000, 4'b0000, 0, 0, 0);
    add(5,  4'b0001, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(1,  4'b0001, 0, 4'b0001, 4'b0001, 1, 0, 0);
    add(2,  4'b0001, 0, 4'b0001, 4'b0000, 0, 0, 0);
    add(5,  4'b0000, 0, 4'b0001, 4'b0000, 0, 0, 0);
    add(1,  4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(2,  4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      btn_raw = tbl[i].raw;
      rst     = tbl[i].rst;
      @(posedge clk);
      #1;
      check_row(i, tbl[i]);
    end

    // Second press while the first is held: ch2 first, ch0 ten cycles later
    rst     = 1'b0;
    btn_raw = 4'b0100;
    p0 = 0; p2 = 0;
    for (int k = 0; k < 25; k++) begin
      if (k == 10) btn_raw = 4'b0101;
      @(posedge clk);
      #1;
      if (btn_press[0]) p0++;
      if (btn_press[2]) p2++;
    end
    check_int("lock_ch2_pulses", p2, 1);
    check_int("lock_ch0_pulses", p0, LOCK_ON ? 0 : 1);
    check_int("lock_level", int'(btn_level), 5);

    // Release both, then press ch0 alone
    btn_raw = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
    end
    check_int("release_level", int'(btn_level), 0);

    btn_raw = 4'b0001;
    p0 = 0; code_at = -1; valid_at = -1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (btn_press[0]) begin
        p0++;
        code_at  = int'(press_code);
        valid_at = int'(press_valid);
      end
    end
    check_int("repress_pulses", p0, 1);
    check_int("repress_code", code_at, 0);
    check_int("repress_valid", valid_at, 1);
    btn_raw = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
